rst_seq_ctrl: RTL and testbench
===============================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 2: rising edges for which core reset is held after rst release; legal range >= 1.
REQ-002 Parameter MAX_CYCLES, default 100: run-cycle limit before timeout; legal range >= 1.
REQ-003 Parameter CNT_W, default 32: cycle counter width; 2^CNT_W-1 >= MAX_CYCLES.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset; forces the reset state immediately.
REQ-006 err  input  1  core error indication.
REQ-007 halt_req  input  1  core program-complete indication.
REQ-008 restart  input  1  one-cycle request to re-run from the reset hold.
REQ-009 core_rst  output  1  reset to core; released synchronously to clk.
REQ-010 run  output  1  core enabled / running.
REQ-011 done  output  1  normal halt reached.
REQ-012 fault  output  1  run ended on err.
REQ-013 timeout  output  1  run ended on cycle limit.
REQ-014 cycle_count  output  CNT_W  rising edges spent in RUN for the current run.

Function
REQ-015 The FSM SHALL have states HOLD, RUN, HALTED, FAULT and TIMEOUT, all registered.
REQ-016 HOLD: core_rst=1, run=0; the hold counter increments each edge; the HOLD_CYCLES-th edge in HOLD SHALL move the FSM to RUN and clear the hold counter.
REQ-017 RUN: core_rst=0, run=1; cycle_count SHALL increment by 1 on every edge at which the state is RUN, including the exit edge.
REQ-018 RUN exit priority, evaluated at each edge: err -> FAULT; else halt_req -> HALTED; else incremented count == MAX_CYCLES -> TIMEOUT; else stay in RUN.
REQ-019 HALTED: core_rst=0, run=0, done=1; FAULT: core_rst=1, run=0, fault=1; TIMEOUT: core_rst=1, run=0, timeout=1.
REQ-020 done, fault and timeout SHALL be decoded from state only, are mutually exclusive, and are 0 in HOLD and RUN.
REQ-021 cycle_count SHALL hold its value in HALTED, FAULT and TIMEOUT, and SHALL never wrap; it saturates at 2^CNT_W-1.
REQ-022 err and halt_req SHALL be ignored outside RUN.
REQ-023 restart in HALTED, FAULT or TIMEOUT SHALL move the FSM to HOLD on the next edge, clearing cycle_count and the hold counter; restart in HOLD or RUN is ignored.
REQ-024 restart coincident with err or halt_req in a terminal state SHALL take restart.
REQ-025 Every output SHALL be a register or a pure decode of registered state, with no combinational path from any input to any output.

Reset
REQ-026 While rst=1: state=HOLD, hold counter=0, cycle_count=0, core_rst=1, run=0, done=0, fault=0, timeout=0.
REQ-027 rst asserted in any state, including mid-RUN between edges, SHALL force the REQ-026 values without waiting for a clock edge.
REQ-028 After rst deasserts, the HOLD_CYCLES-th subsequent rising edge SHALL enter RUN; core_rst falls only at that clock edge, never at the rst edge.

Verification
REQ-029 HOLD_CYCLES=2, rst released at t=201 with 100-unit clock period:
- core_rst stays 1 through the edges at 250 and 350.
- After the edge at 350: run=1 and core_rst=0.
- After the edge at 450: cycle_count=1.
REQ-030 halt_req=1 at the edge where cycle_count goes 10->11:
- done=1, run=0, core_rst=0.
- cycle_count stays frozen at 11 for 20 more cycles.
REQ-031 err=1 and halt_req=1 on the same RUN edge -> fault=1, done=0, core_rst=1.
REQ-032 MAX_CYCLES=100, no err or halt_req -> timeout=1 with cycle_count=100 on the 100th RUN edge; run=0 thereafter.
REQ-033 rst pulsed mid-RUN at cycle_count=37:
- Outputs take the reset values immediately, before the next clock edge.
- The normal 2-edge HOLD follows, then RUN with cycle_count restarting from 0.
REQ-034 restart handling:
- restart pulsed in RUN -> no effect.
- restart pulsed in FAULT -> HOLD with cycle_count=0, then RUN after 2 edges; fault=0 throughout.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: core reset sequencer that holds reset, runs the core, and latches halt/fault/timeout.
module rst_seq_ctrl #(
    parameter int HOLD_CYCLES = 2,
    parameter int MAX_CYCLES  = 100,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err,
    input  logic             halt_req,
    input  logic             restart,
    output logic             core_rst,
    output logic             run,
    output logic             done,
    output logic             fault,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CYCLES);

    typedef enum logic [2:0] {HOLD, RUN, HALTED, FAULT, TIMEOUT} state_t;

    state_t            state, state_nx;
    logic [HW-1:0]     hold_cnt, hold_cnt_nx;
    logic [CNT_W-1:0]  cnt_inc, cnt_nx;
    logic              term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_nx;
            hold_cnt    <= hold_cnt_nx;
            cycle_count <= cnt_nx;
        end
    end

    // Saturate rather than wrap so a long run never reads back as short.
    assign cnt_inc = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
    assign term    = (state == HALTED) || (state == FAULT) || (state == TIMEOUT);

    always_comb begin
        state_nx    = state;
        hold_cnt_nx = hold_cnt;
        cnt_nx      = cycle_count;
        if (state == HOLD) begin
            state_nx    = (hold_cnt == HOLD_LAST) ? RUN : HOLD;
            hold_cnt_nx = (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + HW'(1);
        end else if (state == RUN) begin
            cnt_nx   = cnt_inc;
            state_nx = err ? FAULT : halt_req ? HALTED : (cnt_inc == MAX_C) ? TIMEOUT : RUN;
        end else if (term && restart) begin
            state_nx    = HOLD;
            hold_cnt_nx = '0;
            cnt_nx      = '0;
        end
    end

    always_comb begin
        core_rst = (state == HOLD) || (state == FAULT) || (state == TIMEOUT);
        run      = (state == RUN);
        done     = (state == HALTED);
        fault    = (state == FAULT);
        timeout  = (state == TIMEOUT);
    end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed checks of hold, run, halt, fault, timeout, restart and async reset.
module tb_rst_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err = 1'b0;
    logic        halt_req = 1'b0;
    logic        restart = 1'b0;
    logic        core_rst, run, done, fault, timeout;
    logic [31:0] cycle_count;
    int          total = 0;
    int          bad = 0;

    rst_seq_ctrl dut (
        .clk(clk), .rst(rst), .err(err), .halt_req(halt_req), .restart(restart),
        .core_rst(core_rst), .run(run), .done(done), .fault(fault),
        .timeout(timeout), .cycle_count(cycle_count)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic cr, input logic rn, input logic dn,
                           input logic ft, input logic to, input logic [31:0] cc);
        chk({tag, ".core_rst"}, 32'(core_rst), 32'(cr));
        chk({tag, ".run"}, 32'(run), 32'(rn));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".fault"}, 32'(fault), 32'(ft));
        chk({tag, ".timeout"}, 32'(timeout), 32'(to));
        chk({tag, ".count"}, cycle_count, cc);
    endtask

    initial begin
        #10;
        chk_out("reset", 1, 0, 0, 0, 0, 0);
        #191 rst = 1'b0;
        @(negedge clk);
        chk_out("hold_edge1", 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_out("run_entry", 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("run_count1", cycle_count, 1);
        repeat (4) @(negedge clk);
        chk("run_count5", cycle_count, 5);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk_out("restart_in_run", 0, 1, 0, 0, 0, 6);
        repeat (4) @(negedge clk);
        chk("run_count10", cycle_count, 10);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        chk_out("halted", 0, 0, 1, 0, 0, 11);
        err = 1'b1;
        repeat (20) @(negedge clk);
        err = 1'b0;
        chk_out("halted_frozen", 0, 0, 1, 0, 0, 11);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk_out("restart_hold1", 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_out("restart_hold2", 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_out("restart_run", 0, 1, 0, 0, 0, 0);
        err = 1'b1;
        halt_req = 1'b1;
        @(negedge clk);
        err = 1'b0;
        halt_req = 1'b0;
        chk_out("err_prio", 1, 0, 0, 1, 0, 1);
        restart = 1'b1;
        err = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        err = 1'b0;
        chk_out("fault_restart1", 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_out("fault_restart2", 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_out("fault_restart_run", 0, 1, 0, 0, 0, 0);
        repeat (99) @(negedge clk);
        chk_out("pre_timeout", 0, 1, 0, 0, 0, 99);
        @(negedge clk);
        chk_out("timeout", 1, 0, 0, 0, 1, 100);
        repeat (3) @(negedge clk);
        chk_out("timeout_hold", 1, 0, 0, 0, 1, 100);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        repeat (2) @(negedge clk);
        chk_out("rerun", 0, 1, 0, 0, 0, 0);
        repeat (37) @(negedge clk);
        chk_out("mid_run37", 0, 1, 0, 0, 0, 37);
        #10 rst = 1'b1;
        #1;
        chk_out("async_rst", 1, 0, 0, 0, 0, 0);
        #19 rst = 1'b0;
        @(negedge clk);
        chk_out("post_rst_hold", 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_out("post_rst_run", 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_count1", cycle_count, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
